// File: rtl/memory_io.sv
// Shared request/response types for the 32-bit single-port memory and its upstream arbiters.
`ifndef MEMORY_IO_SV
`define MEMORY_IO_SV

package memory_io;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [3:0]  do_read;
        logic [3:0]  do_write;
        logic [31:0] data;
        logic [7:0]  user_tag;
    } memory_io_req32;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        logic [7:0]  user_tag;
    } memory_io_rsp32;

    localparam memory_io_req32 memory_io_no_req32 = '0;
    localparam memory_io_rsp32 memory_io_no_rsp32 = '0;

    localparam bit ARB_RR    = 1'b1;
    localparam bit ARB_FIXED = 1'b0;

    function automatic logic is_any_byte32(input logic [3:0] be);
        return |be;
    endfunction

endpackage

`endif

// File: rtl/arb_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module arb_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/memory_arbiter32.sv
// Two-client arbiter in front of the 32-bit single-port memory: zero-latency grant,
// one-cycle response routed back to the issuer, stall counters and a sticky protocol-error flag.
`ifndef MEMORY_ARBITER32_SV
`define MEMORY_ARBITER32_SV
`include "memory_io.sv"

module memory_arbiter32
    import memory_io::*;
#(
    parameter bit round_robin = ARB_RR,
    parameter int cnt_width   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  memory_io_req32       c0_req,
    output logic                 c0_ready,
    output memory_io_rsp32       c0_rsp,
    input  memory_io_req32       c1_req,
    output logic                 c1_ready,
    output memory_io_rsp32       c1_rsp,
    output memory_io_req32       mem_req,
    input  memory_io_rsp32       mem_rsp,
    output logic [cnt_width-1:0] c0_stall_cnt,
    output logic [cnt_width-1:0] c1_stall_cnt,
    output logic                 proto_err
);

    logic last_grant_q, last_grant_d;
    logic pend_valid_q, pend_valid_d;
    logic pend_owner_q, pend_owner_d;
    logic proto_err_q, proto_err_d;
    logic gnt0, gnt1;

    // last_grant_q = 1 means c1 won last, so c0 takes the next round-robin contention.
    always_comb begin
        gnt0 = c0_req.valid & (~c1_req.valid | (round_robin & last_grant_q));
        gnt1 = c1_req.valid & ~gnt0;
        if (gnt0) begin
            mem_req = c0_req;
        end else if (gnt1) begin
            mem_req = c1_req;
        end else begin
            mem_req = memory_io_no_req32;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        pend_valid_d = 1'b0;
        pend_owner_d = pend_owner_q;
        if (gnt0 || gnt1) begin
            last_grant_d = gnt1;
            pend_owner_d = gnt1;
            pend_valid_d = is_any_byte32(mem_req.do_read) | is_any_byte32(mem_req.do_write);
        end
        proto_err_d = proto_err_q | (mem_rsp.valid & ~pend_valid_q);
    end

    // Routing uses the owner captured last cycle, not the grant being made now.
    always_comb begin
        c0_rsp = memory_io_no_rsp32;
        c1_rsp = memory_io_no_rsp32;
        if (mem_rsp.valid && pend_valid_q) begin
            if (pend_owner_q) begin
                c1_rsp = mem_rsp;
            end else begin
                c0_rsp = mem_rsp;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            pend_valid_q <= 1'b0;
            pend_owner_q <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            pend_valid_q <= pend_valid_d;
            pend_owner_q <= pend_owner_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign c0_ready  = gnt0;
    assign c1_ready  = gnt1;
    assign proto_err = proto_err_q;

    arb_sat_counter #(.WIDTH(cnt_width)) u_c0_stall (
        .clk    (clk),
        .reset  (reset),
        .inc_i  (c0_req.valid & ~gnt0),
        .count_o(c0_stall_cnt)
    );

    arb_sat_counter #(.WIDTH(cnt_width)) u_c1_stall (
        .clk    (clk),
        .reset  (reset),
        .inc_i  (c1_req.valid & ~gnt1),
        .count_o(c1_stall_cnt)
    );

endmodule

`endif

// File: tb/tb_memory_arbiter32.sv
// Bench for memory_arbiter32: a round-robin/32-bit instance and a fixed-priority/4-bit instance
// share client stimulus; each has its own memory model and reference model.
module tb_memory_arbiter32;
    import memory_io::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    memory_io_req32 c0_req, c1_req;
    memory_io_rsp32 mrsp [2];
    memory_io_req32 mreq [2];
    memory_io_rsp32 c0rsp [2], c1rsp [2];
    logic           rdy0 [2], rdy1 [2], perr [2];
    logic [31:0]    cnt0_rr, cnt1_rr;
    logic [3:0]     cnt0_fx, cnt1_fx;
    logic [31:0]    cnt0_w [2], cnt1_w [2];

    assign cnt0_w[0] = cnt0_rr;
    assign cnt1_w[0] = cnt1_rr;
    assign cnt0_w[1] = {28'b0, cnt0_fx};
    assign cnt1_w[1] = {28'b0, cnt1_fx};

    memory_arbiter32 #(.round_robin(ARB_RR), .cnt_width(32)) dut_rr (
        .clk(clk), .reset(reset),
        .c0_req(c0_req), .c0_ready(rdy0[0]), .c0_rsp(c0rsp[0]),
        .c1_req(c1_req), .c1_ready(rdy1[0]), .c1_rsp(c1rsp[0]),
        .mem_req(mreq[0]), .mem_rsp(mrsp[0]),
        .c0_stall_cnt(cnt0_rr), .c1_stall_cnt(cnt1_rr), .proto_err(perr[0])
    );

    memory_arbiter32 #(.round_robin(ARB_FIXED), .cnt_width(4)) dut_fx (
        .clk(clk), .reset(reset),
        .c0_req(c0_req), .c0_ready(rdy0[1]), .c0_rsp(c0rsp[1]),
        .c1_req(c1_req), .c1_ready(rdy1[1]), .c1_rsp(c1rsp[1]),
        .mem_req(mreq[1]), .mem_rsp(mrsp[1]),
        .c0_stall_cnt(cnt0_fx), .c1_stall_cnt(cnt1_fx), .proto_err(perr[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who won last, what is outstanding, and the debug state.
    int          m_last  [2];
    bit          m_pend  [2];
    int          m_owner [2];
    logic [7:0]  m_tag   [2];
    bit          m_perr  [2];
    longint      m_cnt0  [2], m_cnt1 [2], m_max [2];

    typedef struct {
        bit v0, v1;
        bit rr0, rr1, fx0, fx1;
        int c0rr, c1rr, c0fx;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_last[k] = 1; m_pend[k] = 0; m_owner[k] = 0; m_tag[k] = '0;
            m_perr[k] = 0; m_cnt0[k] = 0; m_cnt1[k] = 0;
        end
    endtask

    function automatic int winner(int k, bit v0, bit v1);
        if (!v0 && !v1) return -1;
        if (v0 && !v1) return 0;
        if (v1 && !v0) return 1;
        if (k == 0) return 1 - m_last[k];
        return 1;
    endfunction

    function automatic memory_io_req32 mk(bit v, logic [31:0] a, logic [7:0] t);
        memory_io_req32 r;
        r = '0;
        r.valid = v;
        r.addr = a;
        r.do_read = v ? 4'hF : 4'h0;
        r.user_tag = t;
        return r;
    endfunction

    task automatic cycle(input memory_io_req32 r0, input memory_io_req32 r1, input bit spur, input bit drop);
        memory_io_req32 ereq, wreq;
        memory_io_rsp32 e0, e1;
        int w;
        @(posedge clk); #1;
        c0_req = r0;
        c1_req = r1;
        for (int k = 0; k < 2; k++) begin
            mrsp[k] = memory_io_no_rsp32;
            if (m_pend[k] && !drop) begin
                mrsp[k].valid = 1'b1;
                mrsp[k].data = {8'hD0, m_tag[k], 16'hBEEF};
                mrsp[k].user_tag = m_tag[k];
            end else if (!m_pend[k] && spur) begin
                mrsp[k].valid = 1'b1;
                mrsp[k].data = $urandom;
                mrsp[k].user_tag = 8'($urandom);
            end
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            w = winner(k, r0.valid, r1.valid);
            ereq = (w == 0) ? r0 : (w == 1) ? r1 : memory_io_no_req32;
            e0 = memory_io_no_rsp32;
            e1 = memory_io_no_rsp32;
            if (mrsp[k].valid && m_pend[k]) begin
                if (m_owner[k] == 0) e0 = mrsp[k];
                else e1 = mrsp[k];
            end
            chk($sformatf("dut%0d c0_ready", k), rdy0[k], w == 0);
            chk($sformatf("dut%0d c1_ready", k), rdy1[k], w == 1);
            chk($sformatf("dut%0d mem_req", k), mreq[k], ereq);
            chk($sformatf("dut%0d c0_rsp", k), c0rsp[k], e0);
            chk($sformatf("dut%0d c1_rsp", k), c1rsp[k], e1);
            chk($sformatf("dut%0d proto_err", k), perr[k], m_perr[k]);
            chk($sformatf("dut%0d c0_stall_cnt", k), cnt0_w[k], 32'(m_cnt0[k]));
            chk($sformatf("dut%0d c1_stall_cnt", k), cnt1_w[k], 32'(m_cnt1[k]));
            if (mrsp[k].valid && !m_pend[k]) m_perr[k] = 1;
            if (r0.valid && w != 0 && m_cnt0[k] < m_max[k]) m_cnt0[k]++;
            if (r1.valid && w != 1 && m_cnt1[k] < m_max[k]) m_cnt1[k]++;
            if (w >= 0) begin
                wreq = (w == 0) ? r0 : r1;
                m_last[k]  = w;
                m_owner[k] = w;
                m_tag[k]   = wreq.user_tag;
                m_pend[k]  = (wreq.do_read != 4'h0) || (wreq.do_write != 4'h0);
            end else begin
                m_pend[k] = 0;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        c0_req = memory_io_no_req32;
        c1_req = memory_io_no_req32;
        mrsp[0] = memory_io_no_rsp32;
        mrsp[1] = memory_io_no_rsp32;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst dut%0d ready", k), {rdy0[k], rdy1[k]}, 2'b00);
            chk($sformatf("rst dut%0d mem_req", k), mreq[k], memory_io_no_req32);
            chk($sformatf("rst dut%0d rsps", k), {c0rsp[k], c1rsp[k]}, {memory_io_no_rsp32, memory_io_no_rsp32});
            chk($sformatf("rst dut%0d proto_err", k), perr[k], 1'b0);
            chk($sformatf("rst dut%0d cnts", k), {cnt0_w[k], cnt1_w[k]}, 64'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        m_reset();
    endtask

    initial begin
        memory_io_req32 none, r0, r1;
        none = memory_io_no_req32;
        c0_req = none;
        c1_req = none;
        mrsp[0] = memory_io_no_rsp32;
        mrsp[1] = memory_io_no_rsp32;
        m_max[0] = 64'hFFFF_FFFF;
        m_max[1] = 15;
        m_reset();

        //             v0 v1 rr0 rr1 fx0 fx1 c0rr c1rr c0fx
        tbl[0] = '{1, 1, 1, 0, 0, 1, 0, 0, 0};
        tbl[1] = '{1, 1, 0, 1, 0, 1, 0, 1, 1};
        tbl[2] = '{1, 1, 1, 0, 0, 1, 1, 1, 2};
        tbl[3] = '{1, 1, 0, 1, 0, 1, 1, 2, 3};
        tbl[4] = '{1, 0, 1, 0, 1, 0, 2, 2, 4};
        tbl[5] = '{0, 1, 0, 1, 0, 1, 2, 2, 4};
        tbl[6] = '{0, 0, 0, 0, 0, 0, 2, 2, 4};
        tbl[7] = '{1, 1, 1, 0, 0, 1, 2, 2, 4};
        tbl[8] = '{0, 0, 0, 0, 0, 0, 2, 3, 5};

        // c0 alone: same-cycle accept, response one cycle later
        do_reset();
        r0 = mk(1, 32'h100, 8'd3);
        cycle(r0, none, 0, 0);
        chk("t1 c0_ready", rdy0[0], 1'b1);
        chk("t1 mem_req.addr", mreq[0].addr, 32'h100);
        cycle(none, none, 0, 0);
        chk("t1 c0_rsp.valid", c0rsp[0].valid, 1'b1);
        chk("t1 c0_rsp.tag", c0rsp[0].user_tag, 8'd3);
        chk("t1 c1_rsp.valid", c1rsp[0].valid, 1'b0);

        // contention table from reset
        do_reset();
        for (int i = 0; i < 9; i++) begin
            cycle(mk(tbl[i].v0, 32'h200 + 32'(i), 8'd3), mk(tbl[i].v1, 32'h300 + 32'(i), 8'd5), 0, 0);
            chk($sformatf("tbl%0d rr ready", i), {rdy0[0], rdy1[0]}, {tbl[i].rr0, tbl[i].rr1});
            chk($sformatf("tbl%0d fx ready", i), {rdy0[1], rdy1[1]}, {tbl[i].fx0, tbl[i].fx1});
            chk($sformatf("tbl%0d rr c0cnt", i), cnt0_rr, 32'(tbl[i].c0rr));
            chk($sformatf("tbl%0d rr c1cnt", i), cnt1_rr, 32'(tbl[i].c1rr));
            chk($sformatf("tbl%0d fx c0cnt", i), cnt0_fx, 4'(tbl[i].c0fx));
        end

        // write with mask, then empty-mask request that gets no response
        do_reset();
        r1 = mk(1, 32'h40, 8'd7);
        r1.do_read = 4'h0;
        r1.do_write = 4'b0011;
        r1.data = 32'hAABBCCDD;
        cycle(none, r1, 0, 0);
        r1 = mk(1, 32'h44, 8'd8);
        r1.do_read = 4'h0;
        cycle(none, r1, 0, 0);
        chk("t4 c1_ready empty", rdy1[0], 1'b1);
        chk("t4 c1_rsp.valid", c1rsp[0].valid, 1'b1);
        chk("t4 c1_rsp.tag", c1rsp[0].user_tag, 8'd7);
        cycle(none, none, 0, 0);
        chk("t4 no rsp", c1rsp[0].valid, 1'b0);
        cycle(none, none, 0, 0);
        chk("t4 proto_err", perr[0], 1'b0);

        // reset with a read outstanding; the late response is a protocol error
        cycle(mk(1, 32'h80, 8'd9), none, 0, 0);
        do_reset();
        cycle(none, none, 1, 0);
        chk("t5 c0_rsp.valid", c0rsp[0].valid, 1'b0);
        chk("t5 c1_rsp.valid", c1rsp[0].valid, 1'b0);
        cycle(none, none, 0, 0);
        chk("t5 proto_err rr", perr[0], 1'b1);
        chk("t5 proto_err fx", perr[1], 1'b1);
        for (int i = 0; i < 3; i++) cycle(none, none, 0, 0);
        chk("t5 proto_err sticky", perr[0], 1'b1);

        // 4-bit counter held stalled 20 cycles
        do_reset();
        for (int i = 0; i < 20; i++) cycle(mk(1, 32'h10, 8'd1), mk(1, 32'h20, 8'd2), 0, 0);
        cycle(none, none, 0, 0);
        chk("t6 fx c0 saturated", cnt0_fx, 4'd15);

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r0 = '0;
            r1 = '0;
            r0.valid = ($urandom_range(0, 9) < 6);
            r1.valid = ($urandom_range(0, 9) < 6);
            r0.addr = $urandom;
            r1.addr = $urandom;
            r0.do_read = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            r1.do_read = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            r0.do_write = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            r1.do_write = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            r0.data = $urandom;
            r1.data = $urandom;
            r0.user_tag = 8'($urandom);
            r1.user_tag = 8'($urandom);
            if (i == 1500) do_reset();
            cycle(r0, r1, ($urandom_range(0, 199) == 0), ($urandom_range(0, 15) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
